// File: rtl/control_pkg.sv
// control_pkg - opcode, state, alu_op and wb_sel encodings shared by the control sequencer.
package control_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam int ALU_ADD  = 0;
  localparam int ALU_CMP  = 1;
  localparam int ALU_FUNC = 2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic op_imm;
    logic op;
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic system;
  } op_class_t;

  function automatic logic writes_rd(input op_class_t c);
    return c.op | c.op_imm | c.load | c.lui | c.auipc | c.jal | c.jalr;
  endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode - combinational opcode to one-hot instruction class and legal flag.
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_class,
  output logic       o_legal
);

  always_comb begin
    o_class = '0;
    o_legal = 1'b1;
    case (i_opcode)
      OP_IMM:  o_class.op_imm = 1'b1;
      OP:      o_class.op     = 1'b1;
      LUI:     o_class.lui    = 1'b1;
      AUIPC:   o_class.auipc  = 1'b1;
      JAL:     o_class.jal    = 1'b1;
      JALR:    o_class.jalr   = 1'b1;
      BRANCH:  o_class.branch = 1'b1;
      LOAD:    o_class.load   = 1'b1;
      STORE:   o_class.store  = 1'b1;
      SYSTEM:  o_class.system = 1'b1;
      default: o_legal        = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm - multi-cycle RV32I control sequencer with memory handshake, timeout and instret.
module control_fsm
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 32,
  parameter int ALU_OP_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                cmp_out,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_sel_d,
  output logic                ir_load,
  output logic                reg_re1,
  output logic                reg_re2,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                alu_sel1,
  output logic                alu_sel2,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                target_load,
  output logic                pc_enable,
  output logic                pc_load,
  output logic                halted,
  output logic                illegal,
  output logic                bus_err,
  output logic [CNT_W-1:0]    instret
);

  localparam logic [TMO_W-1:0] TMO = TMO_W'(MEM_TIMEOUT);

  state_t             r_state;
  state_t             w_next;
  logic               r_taken;
  logic [TMO_W-1:0]   r_wait;
  logic [CNT_W-1:0]   r_instret;
  logic               r_illegal;
  logic               r_bus_err;
  op_class_t          w_class;
  logic               w_legal;
  logic               w_in_access;
  logic               w_timeout;

  control_decode u_decode (
    .i_opcode (opcode),
    .o_class  (w_class),
    .o_legal  (w_legal)
  );

  assign w_in_access = (r_state == ST_FETCH) || (r_state == ST_MEM);
  // A ready arriving on the cycle the count hits the limit still completes the access.
  assign w_timeout   = (MEM_TIMEOUT != 0) && (r_wait == TMO) && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH:  if (mem_ready)      w_next = ST_DECODE;
                 else if (w_timeout) w_next = ST_HALT;
      ST_DECODE: if (!w_legal || w_class.system) w_next = ST_HALT;
                 else                            w_next = ST_EXEC;
      ST_EXEC:   w_next = (w_class.load || w_class.store) ? ST_MEM : ST_WB;
      ST_MEM:    if (mem_ready)      w_next = ST_WB;
                 else if (w_timeout) w_next = ST_HALT;
      ST_WB:     w_next = ST_FETCH;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Wait counter is held at zero outside memory states, so it is clear on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait    <= '0;
      r_taken   <= 1'b0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_in_access && !mem_ready) r_wait <= r_wait + TMO_W'(1);
      else                           r_wait <= '0;
      if (r_state == ST_EXEC)                 r_taken   <= cmp_out;
      if (r_state == ST_WB)                   r_instret <= r_instret + CNT_W'(1);
      if (r_state == ST_DECODE && !w_legal)   r_illegal <= 1'b1;
      if (w_in_access && w_timeout)           r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel_d   = 1'b0;
    ir_load     = 1'b0;
    reg_re1     = 1'b0;
    reg_re2     = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    alu_sel1    = 1'b0;
    alu_sel2    = 1'b0;
    alu_op      = ALU_OP_W'(ALU_ADD);
    target_load = 1'b0;
    pc_enable   = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      ST_DECODE: begin
        reg_re1     = 1'b1;
        reg_re2     = 1'b1;
        target_load = 1'b1;
      end
      ST_EXEC: begin
        alu_sel1    = !(w_class.auipc || w_class.jal);
        alu_sel2    = w_class.op || w_class.branch;
        target_load = w_class.jalr;
        if (w_class.branch)                    alu_op = ALU_OP_W'(ALU_CMP);
        else if (w_class.op || w_class.op_imm) alu_op = ALU_OP_W'(ALU_FUNC);
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_sel_d = 1'b1;
        mem_we    = w_class.store;
      end
      ST_WB: begin
        pc_enable = 1'b1;
        pc_load   = w_class.jal || w_class.jalr || (w_class.branch && r_taken);
        reg_we    = writes_rd(w_class);
        if (w_class.load)                     wb_sel = WB_MEM;
        else if (w_class.jal || w_class.jalr) wb_sel = WB_PC4;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign instret = r_instret;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm - directed checks of the control sequencer paths, wait states, timeout and reset.
module tb_control_fsm;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        cmp_out;
  logic        mem_ready;
  logic [2:0]  state;
  logic        mem_req, mem_we, mem_sel_d, ir_load, reg_re1, reg_re2, reg_we;
  logic [1:0]  wb_sel;
  logic        alu_sel1, alu_sel2;
  logic [2:0]  alu_op;
  logic        target_load, pc_enable, pc_load, halted, illegal, bus_err;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;
  int n_req;

  control_fsm #(.MEM_TIMEOUT(4), .TMO_W(8), .CNT_W(32), .ALU_OP_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cmp_out(cmp_out), .mem_ready(mem_ready),
    .state(state), .mem_req(mem_req), .mem_we(mem_we), .mem_sel_d(mem_sel_d),
    .ir_load(ir_load), .reg_re1(reg_re1), .reg_re2(reg_re2), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .alu_op(alu_op),
    .target_load(target_load), .pc_enable(pc_enable), .pc_load(pc_load),
    .halted(halted), .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle(input logic rdy, input logic cmp);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    cmp_out   = cmp;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 7'b0; cmp_out = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 3'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_instret", instret, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_state", state, 3'd0);

    // ADD, memory always ready
    opcode = 7'b0110011;
    next_cycle(1, 0);
    check("add_fetch", state, 3'd1);
    check("add_fetch_req", mem_req, 1'b1);
    check("add_fetch_irload", ir_load, 1'b1);
    check("add_fetch_seld", mem_sel_d, 1'b0);
    check("add_fetch_we", reg_we, 1'b0);
    next_cycle(1, 0);
    check("add_decode", state, 3'd2);
    check("add_dec_re", {reg_re1, reg_re2, target_load}, 3'b111);
    next_cycle(1, 0);
    check("add_exec", state, 3'd3);
    check("add_exec_sel", {alu_sel1, alu_sel2}, 2'b11);
    check("add_exec_aluop", alu_op, 3'd2);
    check("add_exec_we", reg_we, 1'b0);
    next_cycle(1, 0);
    check("add_wb", state, 3'd5);
    check("add_wb_we", reg_we, 1'b1);
    check("add_wb_pcen", {pc_enable, pc_load}, 2'b10);
    check("add_wb_sel", wb_sel, 2'd0);
    check("add_wb_instret", instret, 32'd0);
    next_cycle(1, 0);
    check("add_refetch", state, 3'd1);
    check("add_instret", instret, 32'd1);

    // LOAD with three wait states in MEM
    opcode = 7'b0000011;
    next_cycle(1, 0);
    check("ld_decode", state, 3'd2);
    next_cycle(1, 0);
    check("ld_exec_sel", {alu_sel1, alu_sel2}, 2'b10);
    check("ld_exec_aluop", alu_op, 3'd0);
    n_req = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle(i == 3, 0);
      check("ld_mem_state", state, 3'd4);
      check("ld_mem_seld", {mem_sel_d, mem_we}, 2'b10);
      if (mem_req) n_req++;
    end
    check("ld_req_cycles", n_req, 32'd4);
    next_cycle(1, 0);
    check("ld_wb", state, 3'd5);
    check("ld_wb_sel", wb_sel, 2'd1);
    check("ld_wb_we", reg_we, 1'b1);
    next_cycle(1, 0);
    check("ld_instret", instret, 32'd2);

    // BEQ taken, then BNE not taken; cmp_out flipped in WB to prove it was captured in EXEC
    opcode = 7'b1100011;
    next_cycle(1, 0);
    next_cycle(1, 1);
    check("beq_exec_aluop", alu_op, 3'd1);
    check("beq_exec_sel", {alu_sel1, alu_sel2}, 2'b11);
    next_cycle(1, 0);
    check("beq_wb_pc", {pc_enable, pc_load}, 2'b11);
    check("beq_wb_we", reg_we, 1'b0);
    next_cycle(1, 0);
    next_cycle(1, 0);
    next_cycle(1, 0);
    next_cycle(1, 1);
    check("bne_wb_pc", {pc_enable, pc_load}, 2'b10);
    next_cycle(1, 0);
    check("br_instret", instret, 32'd4);

    // JAL
    opcode = 7'b1101111;
    next_cycle(1, 0);
    next_cycle(1, 0);
    check("jal_exec_sel", {alu_sel1, alu_sel2}, 2'b00);
    next_cycle(1, 0);
    check("jal_wb", {pc_load, reg_we}, 2'b11);
    check("jal_wb_sel", wb_sel, 2'd2);
    next_cycle(1, 0);
    check("jal_instret", instret, 32'd5);

    // STORE, reset asserted mid-MEM
    opcode = 7'b0100011;
    next_cycle(1, 0);
    next_cycle(1, 0);
    next_cycle(0, 0);
    check("st_mem_state", state, 3'd4);
    check("st_mem_req", {mem_req, mem_we, mem_sel_d}, 3'b111);
    #2;
    reset = 1'b1;
    #1;
    check("st_rst_req", {mem_req, mem_we}, 2'b00);
    check("st_rst_state", state, 3'd0);
    check("st_rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; mem_ready = 1'b0;

    // Ready on the cycle the wait count reaches the limit wins; then illegal opcode
    opcode = 7'b0000000;
    for (int i = 0; i < 4; i++) begin
      next_cycle(0, 0);
      check("bnd_fetch_wait", state, 3'd1);
    end
    next_cycle(1, 0);
    check("bnd_fetch_last", {state, ir_load}, {3'd1, 1'b1});
    next_cycle(0, 0);
    check("bnd_decode", state, 3'd2);
    check("bnd_no_buserr", bus_err, 1'b0);
    next_cycle(0, 0);
    check("ill_halt", state, 3'd6);
    check("ill_flags", {halted, illegal, bus_err}, 3'b110);
    next_cycle(0, 0);
    check("ill_stays", state, 3'd6);
    check("ill_idle_outs", {mem_req, reg_we, pc_enable, target_load}, 4'b0000);
    reset = 1'b1;
    #1;
    check("ill_rst", {state, halted, illegal}, {3'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Stuck memory in FETCH times out after four waits
    for (int i = 0; i < 5; i++) begin
      next_cycle(0, 0);
      check("tmo_fetch", state, 3'd1);
    end
    next_cycle(0, 0);
    check("tmo_halt", state, 3'd6);
    check("tmo_flags", {halted, bus_err, illegal}, 3'b110);
    check("tmo_outs", {mem_req, ir_load, pc_enable, reg_we}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
